// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 7-segment driver: status glyph on digit 0, hex nibbles on the rest.
// Optional feature macro: BLINK_EN (blinks the whole display while the snapshotted state is 3'b101).
module seg7_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEAD_CYC       = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [2:0]                  i_state,
  input  logic [4*(NUM_DIGITS-1)-1:0] i_digits,
  input  logic [NUM_DIGITS-2:0]       i_blank,
  output logic [6:0]                  o_seg,
  output logic [NUM_DIGITS-1:0]       o_an,
  output logic                        o_frame
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [2:0] ST_FAULT = 3'b101;

  function automatic logic [6:0] status_glyph(input logic [2:0] s);
    case (s)
      3'b000, 3'b100:         status_glyph = 7'b0010010;
      3'b001, 3'b010, 3'b011: status_glyph = 7'b1000001;
      3'b101:                 status_glyph = 7'b0001110;
      default:                status_glyph = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Scan counters
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end, frame_end;

  assign slot_end  = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) begin
      presc_d = '0;
      idx_d   = frame_end ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow registers: transparent while in reset so release shows the last reset-cycle inputs
  logic [2:0]                  st_q;
  logic [4*(NUM_DIGITS-1)-1:0] dig_q;
  logic [NUM_DIGITS-2:0]       blk_q;

  assign o_frame = !i_rst && frame_end;

  always_ff @(posedge i_clk) begin
    if (i_rst || frame_end) begin
      st_q  <= i_state;
      dig_q <= i_digits;
      blk_q <= i_blank;
    end
  end

  logic [NUM_DIGITS-1:0][6:0] glyph;

  assign glyph[0] = status_glyph(st_q);

  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_digit
    assign glyph[k] = blk_q[k-1] ? 7'h7F : hex_glyph(dig_q[4*k-1 -: 4]);
  end

  logic blink_on;

`ifdef BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  // Counting happens on frame pulses; the phase only changes at snapshots, so blanking covers whole frames
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (o_frame) begin
      if (i_state == ST_FAULT) begin
        if (st_q != ST_FAULT) begin
          blink_on_d  = 1'b1;
          blink_cnt_d = '0;
        end else if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_on_d  = !blink_on_q;
          blink_cnt_d = '0;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        blink_on_d  = 1'b1;
        blink_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  // Output stage, held internally in active-low form
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  always_comb begin
    seg_d = 7'h7F;
    an_d  = '1;
    if ((int'(presc_q) >= DEAD_CYC) && blink_on) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IW'(k)) begin
          an_d[k] = 1'b0;
          seg_d   = glyph[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign o_seg = (SEG_ACTIVE_LOW != 0) ? seg_q : ~seg_q;
  assign o_an  = (SEG_ACTIVE_LOW != 0) ? an_q  : ~an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: a cycle-count reference model pushes expected
// outputs into a scoreboard queue each clock; they are popped and compared after the edge.
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  st;
  logic [11:0] dig;
  logic [2:0]  blk;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_state(st), .i_digits(dig), .i_blank(blk),
    .o_seg(seg), .o_an(an), .o_frame(frame)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference state: cycles since reset release plus the bench's own snapshot copy
  int          m_c;
  logic [2:0]  m_st;
  logic [11:0] m_dig;
  logic [2:0]  m_blk;
  logic        m_on;
  int          m_cnt;

  function automatic logic [6:0] status_g(input logic [2:0] s);
    case (s)
      3'd0, 3'd4:       return 7'b0010010;
      3'd1, 3'd2, 3'd3: return 7'b1000001;
      3'd5:             return 7'b0001110;
      default:          return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] hex_g(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    exp_t e;
    logic ef;
    int   p, d;
    #1;
    ef = !rst && (m_c % FR == FR - 1);
    check("frame", {15'd0, frame}, {15'd0, ef});
    e = {7'h7F, 4'hF};
    if (!rst) begin
      p = m_c % SD;
      d = (m_c / SD) % ND;
      if (p >= DC && m_on) begin
        e.an  = ~(4'b0001 << d);
        e.seg = (d == 0) ? status_g(m_st) : (m_blk[d-1] ? 7'h7F : hex_g(m_dig[4*d-1 -: 4]));
      end
    end
    q.push_back(e);
    if (rst) begin
      m_c = 0; m_st = st; m_dig = dig; m_blk = blk; m_on = 1'b1; m_cnt = 0;
    end else begin
      if (m_c % FR == FR - 1) begin
`ifdef BLINK_EN
        if (st == 3'd5) begin
          if (m_st != 3'd5) begin m_on = 1'b1; m_cnt = 0; end
          else if (m_cnt == BF - 1) begin m_on = !m_on; m_cnt = 0; end
          else m_cnt++;
        end else begin
          m_on = 1'b1; m_cnt = 0;
        end
`endif
        m_st = st; m_dig = dig; m_blk = blk;
      end
      m_c++;
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("seg", {9'd0, seg}, {9'd0, e.seg});
    check("an", {12'd0, an}, {12'd0, e.an});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FR && (m_c % FR) != ph; i++) cyc();
  endtask

  initial begin
    m_c = 0; m_st = '0; m_dig = '0; m_blk = '0; m_on = 1'b1; m_cnt = 0;

    // Reset held for three clocks
    rst = 1'b1; st = 3'd0; dig = 12'h123; blk = 3'b000;
    run(3);

    // Plain scan: S,3,2,1 over two frames
    rst = 1'b0;
    run(2 * FR);

    // Digit change mid-frame must wait for the next snapshot
    run_to(5);
    dig = 12'h4E7;
    run(FR + 8);

    // State 000 -> 101 while digit 2 is active
    run_to(9);
    st = 3'd5;
    run(FR + 12);

    // Blank digit 2 only
    blk = 3'b010;
    dig = 12'h89A;
    run(2 * FR);
    blk = 3'b000;

    // Hold 101 for several frames (blinks when enabled)
    run(6 * FR);
    st = 3'd2;
    run(2 * FR);

    // Walk the remaining state codes and hex glyphs
    for (int s = 0; s < 8; s++) begin
      st  = 3'(s);
      dig = (s % 2 == 0) ? 12'hBCD : 12'hEF0;
      blk = 3'(s);
      run(FR);
    end
    blk = 3'b000;
    dig = 12'h56F;
    st  = 3'd0;
    run(FR);

    // One-cycle reset during digit 2; shadow must hold reset-cycle inputs
    run_to(9);
    rst = 1'b1; st = 3'd1; dig = 12'hABC; blk = 3'b001;
    cyc();
    rst = 1'b0; st = 3'd6; dig = 12'h000; blk = 3'b000;
    cyc();
    check("post_rst_dead_an", {12'd0, an}, 16'h000F);
    cyc();
    check("post_rst_dig0_an", {12'd0, an}, 16'h000E);
    check("post_rst_dig0_seg", {9'd0, seg}, 16'h0041);
    run(3 * FR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
